// File: rtl/cpu_pkg.sv
// Shared front-end types and constants for the fetch stage.
package cpu_pkg;
  localparam int          CPU_XLEN  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/addr held until gnt, one in-order rvalid per grant.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} pairs; flush beats push and pop, push on full only alongside a pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int  XLEN   = CPU_XLEN,
  parameter int  QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_head_pc,
  output logic [31:0]     o_head_instr,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);
  logic [XLEN-1:0] r_pc_mem    [QDEPTH];
  logic [31:0]     r_instr_mem [QDEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_count      = r_count;
  assign o_full       = (r_count == CW'(QDEPTH));
  assign o_empty      = (r_count == '0);
  assign w_do_pop     = i_pop && !i_flush && !o_empty;
  assign w_do_push    = i_push && !i_flush && (!o_full || w_do_pop);
  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]    <= i_pc;
      r_instr_mem[r_wr_ptr] <= i_instr;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem read in flight and queues returned words for decode.
// Optional FETCH_PERF_EN adds o_perf_fetched / o_perf_stall event counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en_fetch,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_unit_if.master    imem,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_stall
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, r_req_pc;
  logic [XLEN-1:0] w_q_pc;
  logic [31:0]     w_q_instr;
  logic [CW-1:0]   w_q_count;
  logic            w_q_full, w_q_empty;
  logic            w_outstanding, w_has_slot, w_gnt_fire, w_push, w_pop;

  // Only one word may be in flight, so a slot must exist for it before requesting.
  assign w_outstanding = (r_state == S_WAIT) || (r_state == S_DROP);
  assign w_has_slot    = !w_q_full && ((w_q_count + CW'(w_outstanding)) < CW'(QDEPTH));
  assign w_gnt_fire    = (r_state == S_REQ) && imem.gnt;
  assign w_push        = (r_state == S_WAIT) && imem.rvalid && !i_redirect_valid;
  assign w_pop         = i_en_fetch && o_instr_valid && !i_redirect_valid;

  assign imem.req      = (r_state == S_REQ);
  assign imem.addr     = r_pc;
  assign o_fetch_busy  = w_outstanding;
  assign o_instr_valid = !w_q_empty;
  assign o_instr       = o_instr_valid ? w_q_instr : NOP_INSTR;
  assign o_instr_pc    = o_instr_valid ? w_q_pc : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE:  if (w_has_slot) w_state_nxt = S_REQ;
      S_REQ:   if (imem.gnt) begin
                 w_state_nxt = S_WAIT;
                 w_pc_nxt    = r_pc + XLEN'(4);
               end
      S_WAIT:  if (imem.rvalid) w_state_nxt = S_IDLE;
      S_DROP:  if (imem.rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Redirect overrides: a granted or pending word must still be drained, so park in S_DROP.
    if (i_redirect_valid) begin
      w_pc_nxt = i_redirect_pc & ~XLEN'(3);
      case (r_state)
        S_REQ:          w_state_nxt = imem.gnt ? S_DROP : S_IDLE;
        S_WAIT, S_DROP: w_state_nxt = imem.rvalid ? S_IDLE : S_DROP;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_gnt_fire) r_req_pc <= r_pc;
    end
  end

  fetch_queue #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (i_redirect_valid),
    .i_pc         (r_req_pc),
    .i_instr      (imem.rdata),
    .o_head_pc    (w_q_pc),
    .o_head_instr (w_q_instr),
    .o_count      (w_q_count),
    .o_full       (w_q_full),
    .o_empty      (w_q_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (i_en_fetch && !o_instr_valid) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_stall   = r_perf_stall;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, full queue, redirects and mid-flight reset.
module tb_fetch_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rv;
  logic [31:0] rpc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int          n_cmp;
  int          n_bad;
  int          ncyc;
  int          grants;
  bit          mem_auto;
  int          mem_lat;
  bit          pend;
  logic [31:0] paddr;
  int          pcnt;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) m ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_en_fetch       (en),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .imem             (m),
    .o_instr_valid    (o_valid),
    .o_instr          (o_instr),
    .o_instr_pc       (o_pc),
    .o_fetch_busy     (o_busy)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched   (perf_fetched),
    .o_perf_stall     (perf_stall)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Sample at negedge, then drive the next cycle's inputs 1 time unit after posedge.
  task automatic tick();
    bit          fire;
    logic [31:0] faddr;
    @(negedge clk);
    fire  = mem_auto && m.req && m.gnt;
    faddr = m.addr;
    if (fire) grants++;
    @(posedge clk);
    #1;
    ncyc++;
    if (mem_auto) begin
      if (fire) begin pend = 1; paddr = faddr; pcnt = mem_lat; end
      m.rvalid = 1'b0;
      if (pend) begin
        if (pcnt <= 1) begin m.rvalid = 1'b1; m.rdata = word(paddr); pend = 0; end
        else pcnt--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; en = 0; rv = 0; rpc = '0;
    m.gnt = 1; m.rvalid = 0; m.rdata = '0;
    mem_auto = 1; mem_lat = 1; pend = 0;
    tick(); tick();
    rst = 0; ncyc = 0; grants = 0; pend = 0; m.rvalid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", m.req); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", o_instr, NOP); end
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    tick();
    n_cmp++; if (m.req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", m.req); end
    n_cmp++; if (m.addr !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 0", m.addr); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL c2_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL c2_busy: got %b want 1", o_busy); end
    tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL c3_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL c3_pc: got %h want 0", o_pc); end
    n_cmp++; if (o_instr !== 32'hC0DE0000) begin n_bad++; $display("FAIL c3_instr: got %h want C0DE0000", o_instr); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    logic [31:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    en = 1;
    for (int i = 0; i < 13; i++) begin
      if (o_valid) begin pcs.push_back(o_pc); ins.push_back(o_instr); end
      tick();
    end
    n_cmp++; if (pcs.size() != 4) begin n_bad++; $display("FAIL stream_count: got %0d want 4", pcs.size()); end
    for (int i = 0; i < 4 && i < pcs.size(); i++) begin
      n_cmp++; if (pcs[i] !== exp_pc[i]) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pcs[i], exp_pc[i]); end
      n_cmp++; if (ins[i] !== word(exp_pc[i])) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, ins[i], word(exp_pc[i])); end
    end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd4) begin n_bad++; $display("FAIL perf_fetched: got %0d want 4", perf_fetched); end
    n_cmp++; if (perf_stall !== 32'd9) begin n_bad++; $display("FAIL perf_stall: got %0d want 9", perf_stall); end
`endif
    en = 0;
  endtask

  task automatic test_full();
    logic [31:0] pcs[$];
    logic [31:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    int          nreq;
    bit          got;
    logic [31:0] first;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      if (m.req) nreq++;
      tick();
    end
    n_cmp++; if (grants != 2) begin n_bad++; $display("FAIL full_grants: got %0d want 2", grants); end
    n_cmp++; if (nreq != 2) begin n_bad++; $display("FAIL full_req_cycles: got %0d want 2", nreq); end
    n_cmp++; if (m.req !== 1'b0) begin n_bad++; $display("FAIL full_req_idle: got %b want 0", m.req); end
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin n_bad++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", o_valid, o_pc); end
    en = 1; got = 0; first = '0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid) pcs.push_back(o_pc);
      if (m.req && !got) begin got = 1; first = m.addr; end
      tick();
    end
    en = 0;
    n_cmp++; if (!got || first !== 32'h8) begin n_bad++; $display("FAIL resume_addr: got seen=%0d addr=%h want 8", got, first); end
    n_cmp++; if (pcs.size() != 4) begin n_bad++; $display("FAIL resume_count: got %0d want 4", pcs.size()); end
    for (int i = 0; i < 4 && i < pcs.size(); i++) begin
      n_cmp++; if (pcs[i] !== exp_pc[i]) begin n_bad++; $display("FAIL resume_pc[%0d]: got %h want %h", i, pcs[i], exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_wait();
    bit          seen;
    bit          done;
    logic [31:0] first;
    logic [31:0] vpc;
    logic [31:0] vin;
    do_reset();
    mem_lat = 3;
    tick(); tick();
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rdw_busy_wait: got %b want 1", o_busy); end
    rv = 1; rpc = 32'h103;
    tick();
    rv = 0; rpc = '0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rdw_busy_drop: got %b want 1", o_busy); end
    seen = 0; done = 0; first = '0; vpc = '0; vin = '0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (m.req && !seen) begin seen = 1; first = m.addr; end
      if (o_valid) begin done = 1; vpc = o_pc; vin = o_instr; end
      else tick();
    end
    n_cmp++; if (!seen || first !== 32'h100) begin n_bad++; $display("FAIL rdw_addr: got seen=%0d addr=%h want 100", seen, first); end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rdw_timeout: got no instr_valid want one within 30 cycles"); end
    n_cmp++; if (vpc !== 32'h100) begin n_bad++; $display("FAIL rdw_pc: got %h want 100", vpc); end
    n_cmp++; if (vin !== 32'hC0DE0100) begin n_bad++; $display("FAIL rdw_instr: got %h want C0DE0100", vin); end
  endtask

  task automatic test_redirect_flush();
    bit          done;
    logic [31:0] vpc;
    do_reset();
    repeat (8) tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rdf_prefill: got %b want 1", o_valid); end
    rv = 1; rpc = 32'h200; en = 1;
    tick();
    rv = 0; rpc = '0; en = 0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rdf_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_instr !== NOP) begin n_bad++; $display("FAIL rdf_instr: got %h want %h", o_instr, NOP); end
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL rdf_pc: got %h want 0", o_pc); end
    done = 0; vpc = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (o_valid) begin done = 1; vpc = o_pc; end
      else tick();
    end
    n_cmp++; if (!done || vpc !== 32'h200) begin n_bad++; $display("FAIL rdf_restart: got done=%0d pc=%h want 200", done, vpc); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem_auto = 0; m.gnt = 1;
    tick(); tick();
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_wait_busy: got %b want 1", o_busy); end
    rst = 1;
    tick();
    rst = 0; m.gnt = 0; m.rvalid = 1; m.rdata = 32'hDEADBEEF;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    tick();
    m.rvalid = 0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_late_valid: got %b want 0", o_valid); end
    n_cmp++; if (m.req !== 1'b1 || m.addr !== 32'h0) begin n_bad++; $display("FAIL rst_next_req: got req=%b addr=%h want 1/0", m.req, m.addr); end
    tick();
    n_cmp++; if (m.req !== 1'b1 || m.addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr_hold: got req=%b addr=%h want 1/0", m.req, m.addr); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_late_valid2: got %b want 0", o_valid); end
    mem_auto = 1; m.gnt = 1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; ncyc = 0; grants = 0;
    rst = 1; en = 0; rv = 0; rpc = '0;
    m.gnt = 0; m.rvalid = 0; m.rdata = '0;
    mem_auto = 1; mem_lat = 1; pend = 0; paddr = '0; pcnt = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_flush();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
